stopwatch_ctrl: RTL

Stopwatch sequencer that drives the 4-digit 7-segment display driver with a 16-bit BCD MM:SS value.
- Runs off the same 500 Hz scan clock; derives a 1 s tick internally.
- Digit order: [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units.
- Handles start/stop, lap freeze, clear, and overflow; overflow is shown as "dddd" using the driver's 'd' glyph.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/stopwatch_bcd_time.sv | 64 ++++++
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch sequencer.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        LAP   = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [15:0] BCD_DONE     = 16'hdddd;
    localparam logic [3:0]  MAX_SEC_TENS = 4'd5;
    localparam logic [3:0]  MAX_DIGIT    = 4'd9;

endpackage

// File: rtl/stopwatch_bcd_time.sv
// MM:SS BCD counter; saturates at 59:59 and clears synchronously on clr_i.
module stopwatch_bcd_time
    import stopwatch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] time_o,
    output logic        at_max_o
);

    logic [3:0] sec_u_q, sec_t_q, min_u_q, min_t_q;
    logic [3:0] sec_u_d, sec_t_d, min_u_d, min_t_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sec_u_q <= '0;
            sec_t_q <= '0;
            min_u_q <= '0;
            min_t_q <= '0;
        end else begin
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
        end
    end

    // Ripple carry through the digits; the top digit never passes 5 because 59:59 blocks inc.
    always_comb begin
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        if (clr_i) begin
            sec_u_d = '0;
            sec_t_d = '0;
            min_u_d = '0;
            min_t_d = '0;
        end else if (inc_i && !at_max_o) begin
            if (sec_u_q != MAX_DIGIT) begin
                sec_u_d = sec_u_q + 4'd1;
            end else begin
                sec_u_d = '0;
                if (sec_t_q != MAX_SEC_TENS) begin
                    sec_t_d = sec_t_q + 4'd1;
                end else begin
                    sec_t_d = '0;
                    if (min_u_q != MAX_DIGIT) begin
                        min_u_d = min_u_q + 4'd1;
                    end else begin
                        min_u_d = '0;
                        min_t_d = min_t_q + 4'd1;
                    end
                end
            end
        end
    end

    assign time_o   = {min_t_q, min_u_q, sec_t_q, sec_u_q};
    assign at_max_o = (time_o == {MAX_SEC_TENS, MAX_DIGIT, MAX_SEC_TENS, MAX_DIGIT});

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge detect, 1 s prescaler, state machine and display mux.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500
) (
    input  logic        clk500hz,
    input  logic        rstn,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [15:0] bcd_num,
    output logic        running,
    output logic        lap_active,
    output logic        done
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] snap_q, snap_d;
    logic        prev_ss_q, prev_lap_q, prev_clr_q;

    logic        ev_ss, ev_lap, ev_clr;
    logic        counting, tick, go_idle, inc;
    logic [15:0] cur_time;
    logic        at_max;

    assign ev_ss    = btn_start_stop & ~prev_ss_q;
    assign ev_lap   = btn_lap & ~prev_lap_q;
    assign ev_clr   = btn_clear & ~prev_clr_q;
    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick     = counting && (presc_q == TICK_LAST);
    assign go_idle  = (state_d == IDLE) && (state_q != IDLE);
    assign inc      = tick && !at_max;

    stopwatch_bcd_time u_time (
        .clk_i    (clk500hz),
        .rst_ni   (rstn),
        .inc_i    (inc),
        .clr_i    (go_idle),
        .time_o   (cur_time),
        .at_max_o (at_max)
    );

    always_ff @(posedge clk500hz or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Prev registers reset high so a button held through reset needs a release first.
    always_ff @(posedge clk500hz or negedge rstn) begin
        if (!rstn) begin
            presc_q    <= '0;
            snap_q     <= '0;
            prev_ss_q  <= 1'b1;
            prev_lap_q <= 1'b1;
            prev_clr_q <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            snap_q     <= snap_d;
            prev_ss_q  <= btn_start_stop;
            prev_lap_q <= btn_lap;
            prev_clr_q <= btn_clear;
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (go_idle || tick) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = presc_q + 16'd1;
        end
    end

    always_comb begin
        snap_d = snap_q;
        if (state_q == RUN && state_d == LAP) begin
            snap_d = cur_time;
        end
    end

    // Overflow on the final tick outranks any button in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ev_ss) state_d = RUN;
            end
            RUN: begin
                if (tick && at_max)  state_d = DONE;
                else if (ev_ss)      state_d = PAUSE;
                else if (ev_lap)     state_d = LAP;
            end
            LAP: begin
                if (tick && at_max)  state_d = DONE;
                else if (ev_ss)      state_d = PAUSE;
                else if (ev_lap)     state_d = RUN;
            end
            PAUSE: begin
                if (ev_clr)          state_d = IDLE;
                else if (ev_ss)      state_d = RUN;
            end
            DONE: begin
                if (ev_clr)          state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bcd_num    = cur_time;
        running    = 1'b0;
        lap_active = 1'b0;
        done       = 1'b0;
        case (state_q)
            RUN: begin
                running = 1'b1;
            end
            LAP: begin
                running    = 1'b1;
                lap_active = 1'b1;
                bcd_num    = snap_q;
            end
            DONE: begin
                done    = 1'b1;
                bcd_num = BCD_DONE;
            end
            default: ;
        endcase
    end

endmodule
